ahb_slave_rr_burst_arbiter: RTL and testbench

Per-slave round-robin arbiter that shares one AHB slave port among `MASTER_NUM` masters. It holds ownership for the full duration of a defined-length or INCR burst, rotates priority when the burst completes, and releases masters that win the grant but never start a transfer. It sits between the master-side request lines and the slave-side address/control mux, and drives that mux's select index.

---
 rtl/AHB_package.sv | 38 +++
 rtl/ahb_rr_pick.sv | 30 +++
 rtl/ahb_slave_rr_burst_arbiter.sv | 155 +++++++++++++++
 tb/tb_ahb_slave_rr_burst_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/AHB_package.sv
// rtl/AHB_package.sv - shared AHB transfer/burst types and arbiter helpers
package AHB_package;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } htrans_type;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } hburst_type;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_BURST = 2'd2
   } arb_state_type;

   // Index of the last beat of a fixed-length burst; INCR has no limit.
   function automatic logic [3:0] burst_limit(input hburst_type b);
      case (b)
         INCR4, WRAP4:   return 4'd3;
         INCR8, WRAP8:   return 4'd7;
         INCR16, WRAP16: return 4'd15;
         default:        return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// rtl/ahb_rr_pick.sv - rotating priority encoder, ptr has highest priority
module ahb_rr_pick #(
   parameter int N  = 4,
   parameter int MW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [MW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic [MW-1:0] win_idx,
   output logic          any
);

   logic [MW-1:0] idx;

   always_comb begin
      win     = '0;
      win_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx = MW'((int'(ptr) + k) % N);
         if (!any && req[idx]) begin
            any      = 1'b1;
            win[idx] = 1'b1;
            win_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/ahb_slave_rr_burst_arbiter.sv
// rtl/ahb_slave_rr_burst_arbiter.sv - per-slave round-robin arbiter holding ownership across bursts
module ahb_slave_rr_burst_arbiter
   import AHB_package::*;
#(
   parameter int MASTER_NUM    = 4,
   parameter int GRANT_TIMEOUT = 15
) (
   input  logic                          hclk,
   input  logic                          hreset,
   input  logic [MASTER_NUM-1:0]         hreq,
   input  htrans_type                    htrans,
   input  hburst_type                    hburst,
   input  logic                          hready,
   output logic [MASTER_NUM-1:0]         hgrant,
   output logic [$clog2(MASTER_NUM)-1:0] hmaster,
   output logic                          hsel,
   output logic                          hlast,
   output logic                          htimeout
);

   localparam int MW = $clog2(MASTER_NUM);

   arb_state_type         state, state_nxt;
   hburst_type            burst_q, burst_nxt;
   logic [3:0]            beat_cnt, beat_nxt, limit, limit_nxt;
   logic [7:0]            tmo_cnt, tmo_nxt;
   logic [MW-1:0]         rr_ptr, rr_ptr_nxt, owner_next_ptr, pick_ptr, hmaster_nxt, win_idx;
   logic [MASTER_NUM-1:0] hgrant_nxt, win;
   logic                  any, end_own, tmo_hit;

   assign owner_next_ptr = (hmaster == MW'(MASTER_NUM - 1)) ? '0 : hmaster + MW'(1);
   // On a handover the pointer is already rotated so the new winner is found this cycle.
   assign pick_ptr       = end_own ? owner_next_ptr : rr_ptr;
   assign tmo_hit        = (htrans != NONSEQ) && (int'(tmo_cnt) + 1 >= GRANT_TIMEOUT);
   assign hsel           = |hgrant;

   ahb_rr_pick #(.N(MASTER_NUM), .MW(MW)) u_pick (
      .req     (hreq),
      .ptr     (pick_ptr),
      .win     (win),
      .win_idx (win_idx),
      .any     (any)
   );

   always_comb begin
      end_own  = 1'b0;
      hlast    = 1'b0;
      htimeout = 1'b0;
      if (hready) begin
         case (state)
            ARB_GRANT: begin
               if (htrans == NONSEQ) begin
                  if (hburst == SINGLE) begin
                     end_own = 1'b1;
                     hlast   = 1'b1;
                  end
               end else if (tmo_hit) begin
                  end_own  = 1'b1;
                  htimeout = 1'b1;
               end else if (!hreq[hmaster]) begin
                  end_own = 1'b1;
               end
            end
            ARB_BURST: begin
               if (burst_q == INCR) begin
                  if (htrans == IDLE || htrans == NONSEQ) begin
                     end_own = 1'b1;
                     hlast   = 1'b1;
                  end
               end else if (htrans == IDLE ||
                            (htrans == SEQ && beat_cnt == limit - 4'd1)) begin
                  end_own = 1'b1;
                  hlast   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt   = state;
      hgrant_nxt  = hgrant;
      hmaster_nxt = hmaster;
      rr_ptr_nxt  = rr_ptr;
      burst_nxt   = burst_q;
      limit_nxt   = limit;
      beat_nxt    = beat_cnt;
      tmo_nxt     = tmo_cnt;
      // The grant timer keeps running through wait states.
      if (state == ARB_GRANT && htrans != NONSEQ && tmo_cnt != 8'hFF)
         tmo_nxt = tmo_cnt + 8'd1;
      if (end_own) begin
         rr_ptr_nxt = owner_next_ptr;
         tmo_nxt    = '0;
         beat_nxt   = '0;
         if (any) begin
            hgrant_nxt  = win;
            hmaster_nxt = win_idx;
            state_nxt   = ARB_GRANT;
         end else begin
            hgrant_nxt  = '0;
            hmaster_nxt = '0;
            state_nxt   = ARB_IDLE;
         end
      end else if (hready) begin
         case (state)
            ARB_IDLE: begin
               if (any) begin
                  hgrant_nxt  = win;
                  hmaster_nxt = win_idx;
                  tmo_nxt     = '0;
                  state_nxt   = ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               if (htrans == NONSEQ) begin
                  burst_nxt = hburst;
                  limit_nxt = burst_limit(hburst);
                  beat_nxt  = '0;
                  state_nxt = ARB_BURST;
               end
            end
            ARB_BURST: begin
               if (htrans == SEQ)
                  beat_nxt = beat_cnt + 4'd1;
            end
            default: state_nxt = ARB_IDLE;
         endcase
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state    <= ARB_IDLE;
         hgrant   <= '0;
         hmaster  <= '0;
         rr_ptr   <= '0;
         burst_q  <= SINGLE;
         limit    <= '0;
         beat_cnt <= '0;
         tmo_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         hgrant   <= hgrant_nxt;
         hmaster  <= hmaster_nxt;
         rr_ptr   <= rr_ptr_nxt;
         burst_q  <= burst_nxt;
         limit    <= limit_nxt;
         beat_cnt <= beat_nxt;
         tmo_cnt  <= tmo_nxt;
      end
   end

endmodule

// File: tb/tb_ahb_slave_rr_burst_arbiter.sv
// tb/tb_ahb_slave_rr_burst_arbiter.sv - directed self-checking bench for the round-robin burst arbiter
module tb_ahb_slave_rr_burst_arbiter;
   import AHB_package::*;

   logic       hclk = 1'b0;
   logic       hreset;
   logic [3:0] hreq;
   htrans_type htrans;
   hburst_type hburst;
   logic       hready;
   logic [3:0] hgrant;
   logic [1:0] hmaster;
   logic       hsel, hlast, htimeout;

   int n_assert = 0;
   int n_fail   = 0;

   ahb_slave_rr_burst_arbiter #(.MASTER_NUM(4), .GRANT_TIMEOUT(15)) dut (
      .hclk     (hclk),
      .hreset   (hreset),
      .hreq     (hreq),
      .htrans   (htrans),
      .hburst   (hburst),
      .hready   (hready),
      .hgrant   (hgrant),
      .hmaster  (hmaster),
      .hsel     (hsel),
      .hlast    (hlast),
      .htimeout (htimeout)
   );

   always #5 hclk = ~hclk;

   task automatic cyc();
      @(posedge hclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      hreset = 1'b1;
      hreq   = 4'b0000;
      htrans = IDLE;
      hburst = SINGLE;
      hready = 1'b1;
      cyc();
      cyc();
      chk("rst_hgrant", 32'(hgrant), 32'h0);
      chk("rst_hmaster", 32'(hmaster), 32'h0);
      chk("rst_hsel", 32'(hsel), 32'h0);
      chk("rst_hlast", 32'(hlast), 32'h0);
      chk("rst_htimeout", 32'(htimeout), 32'h0);

      // Requests 1010 from reset: M1 wins, SINGLE hands over to M3
      hreset = 1'b0;
      hreq   = 4'b1010;
      cyc();
      chk("t1_hgrant_m1", 32'(hgrant), 32'h2);
      chk("t1_hmaster_m1", 32'(hmaster), 32'h1);
      chk("t1_hsel", 32'(hsel), 32'h1);
      htrans = NONSEQ;
      hburst = SINGLE;
      #1;
      chk("t1_hlast_single", 32'(hlast), 32'h1);
      cyc();
      htrans = IDLE;
      #1;
      chk("t1_hmaster_m3", 32'(hmaster), 32'h3);
      chk("t1_hgrant_m3", 32'(hgrant), 32'h8);
      chk("t1_hlast_clear", 32'(hlast), 32'h0);

      // M3 SINGLE with all requesting: M0 next, then INCR8 with wait states
      hreq   = 4'b1111;
      htrans = NONSEQ;
      cyc();
      chk("t2_hmaster_m0", 32'(hmaster), 32'h0);
      hburst = INCR8;
      cyc();
      for (int i = 0; i < 7; i++) begin
         htrans = SEQ;
         hready = 1'b0;
         #1;
         chk("t2_hlast_wait", 32'(hlast), 32'h0);
         cyc();
         hready = 1'b1;
         #1;
         chk("t2_hlast_beat", 32'(hlast), (i == 6) ? 32'h1 : 32'h0);
         if (i == 3)
            chk("t2_no_preempt", 32'(hmaster), 32'h0);
         cyc();
      end
      htrans = IDLE;
      #1;
      chk("t2_hmaster_m1", 32'(hmaster), 32'h1);
      chk("t2_hgrant_m1", 32'(hgrant), 32'h2);

      // M1 SINGLE passes to M2, which runs INCR with 5 SEQ then IDLE
      htrans = NONSEQ;
      hburst = SINGLE;
      cyc();
      chk("t3_hmaster_m2", 32'(hmaster), 32'h2);
      hburst = INCR;
      cyc();
      htrans = SEQ;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t3_hlast_seq", 32'(hlast), 32'h0);
         cyc();
      end
      htrans = IDLE;
      hreq   = 4'b0001;
      #1;
      chk("t3_hlast_idle", 32'(hlast), 32'h1);
      cyc();
      chk("t3_rr_ptr", 32'(dut.rr_ptr), 32'h3);
      chk("t3_hmaster_m0", 32'(hmaster), 32'h0);

      // M0 stays IDLE: revoked on the 15th cycle, M1 takes over
      hreq = 4'b0011;
      for (int k = 1; k <= 15; k++) begin
         #1;
         chk("t4_htimeout", 32'(htimeout), (k == 15) ? 32'h1 : 32'h0);
         chk("t4_hlast", 32'(hlast), 32'h0);
         cyc();
      end
      chk("t4_hmaster_m1", 32'(hmaster), 32'h1);
      chk("t4_htimeout_after", 32'(htimeout), 32'h0);

      // WRAP4 cut short after 2 beats
      htrans = NONSEQ;
      hburst = WRAP4;
      cyc();
      htrans = SEQ;
      cyc();
      htrans = IDLE;
      #1;
      chk("t5_hlast_early", 32'(hlast), 32'h1);
      cyc();
      chk("t5_rr_ptr", 32'(dut.rr_ptr), 32'h2);
      chk("t5_hmaster_m0", 32'(hmaster), 32'h0);

      // Reset during beat 3 of INCR16
      htrans = NONSEQ;
      hburst = INCR16;
      cyc();
      htrans = SEQ;
      cyc();
      hreset = 1'b1;
      #1;
      chk("t6_hgrant", 32'(hgrant), 32'h0);
      chk("t6_hmaster", 32'(hmaster), 32'h0);
      chk("t6_hsel", 32'(hsel), 32'h0);
      chk("t6_hlast", 32'(hlast), 32'h0);
      chk("t6_htimeout", 32'(htimeout), 32'h0);
      htrans = IDLE;
      hreq   = 4'b1111;
      cyc();
      hreset = 1'b0;
      cyc();
      chk("t6_restart_m0", 32'(hmaster), 32'h0);
      chk("t6_restart_grant", 32'(hgrant), 32'h1);

      // Lone requester regains the bus, then drops its request
      hreq   = 4'b0001;
      htrans = NONSEQ;
      hburst = SINGLE;
      #1;
      chk("t7_hlast", 32'(hlast), 32'h1);
      cyc();
      htrans = IDLE;
      chk("t7_regrant", 32'(hgrant), 32'h1);
      hreq = 4'b0000;
      #1;
      chk("t7_drop_hlast", 32'(hlast), 32'h0);
      chk("t7_drop_htimeout", 32'(htimeout), 32'h0);
      cyc();
      chk("t7_released", 32'(hgrant), 32'h0);
      chk("t7_hsel_low", 32'(hsel), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
